cdec8_ctrl: RTL and testbench

//  Control unit (sequencer) for the CDEC8 8-bit datapath: a multi-cycle FSM that fetches, decodes and executes

---
 rtl/cdec8_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_cdec8_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdec8_ctrl.sv
// cdec8_ctrl
// Multi-cycle sequencer for the CDEC8 8-bit datapath. It fetches an opcode
// byte and, for two-byte instructions, an operand byte. It then decodes and
// executes the instruction by driving the datapath control word from the
// current state, the instruction register and the flags.
//
// Ports
//   clock    in   1   system clock, all state changes on the rising edge
//   reset_N  in   1   asynchronous, active-low reset
//   I        in   8   instruction register from the datapath
//   SZCy     in   3   flags {S,Z,Cy} from the datapath FLG register
//   run      in   1   1 = allow fetch of the next instruction
//   ctrl     out  17  {mmrw[1:0],fwr,rwr,xdst[3:0],aluop[4:0],xsrc[3:0]}
//   halted   out  1   1 while parked in the HLT state
//   state    out  8   current FSM state code, also read by the debug monitor

module cdec8_ctrl (
    input  logic        clock,
    input  logic        reset_N,
    input  logic [7:0]  I,
    input  logic [2:0]  SZCy,
    input  logic        run,
    output logic [16:0] ctrl,
    output logic        halted,
    output logic [7:0]  state
);

    localparam logic [4:0] ALU_THRU = 5'h00;
    localparam logic [4:0] ALU_INC  = 5'h01;
    localparam logic [4:0] ALU_ADD  = 5'h02;
    localparam logic [4:0] ALU_SUB  = 5'h03;
    localparam logic [4:0] ALU_AND  = 5'h04;
    localparam logic [4:0] ALU_OR   = 5'h05;
    localparam logic [4:0] ALU_XOR  = 5'h06;

    localparam logic [3:0] XS_PC    = 4'h0;
    localparam logic [3:0] XS_R     = 4'h4;
    localparam logic [3:0] XS_RDR   = 4'h5;
    localparam logic [3:0] XS_IPORT = 4'h8;
    localparam logic [3:0] XS_NONE  = 4'hF;

    localparam logic [3:0] XD_PC    = 4'h0;
    localparam logic [3:0] XD_MAR   = 4'h4;
    localparam logic [3:0] XD_WDR   = 4'h5;
    localparam logic [3:0] XD_T     = 4'h6;
    localparam logic [3:0] XD_I     = 4'h7;
    localparam logic [3:0] XD_OPORT = 4'h8;
    localparam logic [3:0] XD_NONE  = 4'hF;

    localparam logic [1:0] MM_IDLE  = 2'b00;
    localparam logic [1:0] MM_WRITE = 2'b01;
    localparam logic [1:0] MM_READ  = 2'b10;

    localparam logic [16:0] IDLE_WORD = 17'h01E0F;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_IN   = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JCC  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;

    typedef enum logic [7:0] {
        ST_F0  = 8'h00,
        ST_F1  = 8'h01,
        ST_F2  = 8'h02,
        ST_DEC = 8'h03,
        ST_O0  = 8'h04,
        ST_O1  = 8'h05,
        ST_WB  = 8'h06,
        ST_MA  = 8'h07,
        ST_MR  = 8'h08,
        ST_SW  = 8'h09,
        ST_SM  = 8'h0A,
        ST_AT  = 8'h0B,
        ST_AC  = 8'h0C,
        ST_AR  = 8'h0D,
        ST_HLT = 8'hFF
    } state_t;

    state_t cur_state;

    logic [3:0] op;
    logic [3:0] rd_code;
    logic [3:0] rs_code;
    logic       uses_rd;
    logic       uses_rs;
    logic       illegal;
    logic       cond_true;
    logic [4:0] alu_sel;

    // Register field to bus code: A, B and C share codes 1..3 on both buses.
    function automatic logic [3:0] reg_code(input logic [1:0] field);
        case (field)
            2'd0:    reg_code = 4'h1;
            2'd1:    reg_code = 4'h2;
            2'd2:    reg_code = 4'h3;
            default: reg_code = 4'hF;
        endcase
    endfunction

    assign op      = I[7:4];
    assign rd_code = reg_code(I[3:2]);
    assign rs_code = reg_code(I[1:0]);

    // Instruction decode. Register field 3 only halts the machine when the
    // opcode actually reads or writes that field. Jcc uses I[1:0] as its
    // condition, so it never counts as a register use.
    always_comb begin
        uses_rd = 1'b0;
        uses_rs = 1'b0;
        alu_sel = ALU_THRU;
        case (op)
            OP_LD, OP_LDI, OP_IN: uses_rd = 1'b1;
            OP_ST, OP_OUT:        uses_rs = 1'b1;
            OP_MOV: begin
                uses_rd = 1'b1;
                uses_rs = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                uses_rd = 1'b1;
                uses_rs = 1'b1;
            end
            default: ;
        endcase
        case (op)
            OP_ADD:  alu_sel = ALU_ADD;
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            OP_XOR:  alu_sel = ALU_XOR;
            default: alu_sel = ALU_THRU;
        endcase
        case (I[1:0])
            2'd0:    cond_true = SZCy[1];
            2'd1:    cond_true = ~SZCy[1];
            2'd2:    cond_true = SZCy[0];
            default: cond_true = SZCy[2];
        endcase
        illegal = (op == OP_HALT) || (op == 4'hF) ||
                  (uses_rd && (I[3:2] == 2'd3)) ||
                  (uses_rs && (I[1:0] == 2'd3));
    end

    // Sequencer. Fetch is F0-F2. Operand-byte instructions take the second
    // fetch O0/O1. Memory and ALU work gets its own short chains. Every
    // legal path returns to F0, and run is only looked at there, so
    // dropping run mid-instruction lets the instruction finish first.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            cur_state <= ST_F0;
        end else begin
            case (cur_state)
                ST_F0:  if (run) cur_state <= ST_F1;
                ST_F1:  cur_state <= ST_F2;
                ST_F2:  cur_state <= ST_DEC;
                ST_DEC: begin
                    if (illegal) begin
                        cur_state <= ST_HLT;
                    end else begin
                        case (op)
                            OP_NOP:                         cur_state <= ST_F0;
                            OP_LD, OP_ST, OP_LDI,
                            OP_JMP, OP_JCC:                 cur_state <= ST_O0;
                            OP_MOV, OP_IN, OP_OUT:          cur_state <= ST_WB;
                            OP_ADD, OP_SUB, OP_AND,
                            OP_OR, OP_XOR:                  cur_state <= ST_AT;
                            default:                        cur_state <= ST_HLT;
                        endcase
                    end
                end
                ST_O0:  cur_state <= ST_O1;
                ST_O1:  cur_state <= ((op == OP_LD) || (op == OP_ST)) ? ST_MA : ST_WB;
                ST_MA:  cur_state <= (op == OP_LD) ? ST_MR : ST_SW;
                ST_MR:  cur_state <= ST_WB;
                ST_SW:  cur_state <= ST_SM;
                ST_SM:  cur_state <= ST_F0;
                ST_AT:  cur_state <= ST_AC;
                ST_AC:  cur_state <= ST_AR;
                ST_AR:  cur_state <= ST_F0;
                ST_WB:  cur_state <= ST_F0;
                ST_HLT: cur_state <= ST_HLT;
                default: cur_state <= ST_F0;
            endcase
        end
    end

    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [3:0] xdst;
    logic [4:0] aluop;
    logic [3:0] xsrc;

    // Control word. Each field starts at its idle value and the current
    // state overrides only the fields it needs. In F0 and O0 the PC goes
    // through the ALU incrementer into MAR, with R latched by rwr. fwr stays
    // low there, so PC increments never change the flags.
    always_comb begin
        mmrw  = MM_IDLE;
        fwr   = 1'b0;
        rwr   = 1'b0;
        xdst  = XD_NONE;
        aluop = ALU_THRU;
        xsrc  = XS_NONE;
        case (cur_state)
            ST_F0: begin
                if (run) begin
                    xsrc  = XS_PC;
                    aluop = ALU_INC;
                    rwr   = 1'b1;
                    xdst  = XD_MAR;
                end
            end
            ST_O0: begin
                xsrc  = XS_PC;
                aluop = ALU_INC;
                rwr   = 1'b1;
                xdst  = XD_MAR;
            end
            ST_F1, ST_O1: begin
                xsrc = XS_R;
                xdst = XD_PC;
                mmrw = MM_READ;
            end
            ST_F2: begin
                xsrc = XS_RDR;
                xdst = XD_I;
            end
            ST_MA: begin
                xsrc = XS_RDR;
                xdst = XD_MAR;
            end
            ST_MR: mmrw = MM_READ;
            ST_SW: begin
                xsrc = rs_code;
                xdst = XD_WDR;
            end
            ST_SM: mmrw = MM_WRITE;
            ST_AT: begin
                xsrc = rs_code;
                xdst = XD_T;
            end
            ST_AC: begin
                xsrc  = rd_code;
                aluop = alu_sel;
                rwr   = 1'b1;
                fwr   = 1'b1;
            end
            ST_AR: begin
                xsrc = XS_R;
                xdst = rd_code;
            end
            ST_WB: begin
                case (op)
                    OP_LD, OP_LDI: begin
                        xsrc = XS_RDR;
                        xdst = rd_code;
                    end
                    OP_MOV: begin
                        xsrc = rs_code;
                        xdst = rd_code;
                    end
                    OP_IN: begin
                        xsrc = XS_IPORT;
                        xdst = rd_code;
                    end
                    OP_OUT: begin
                        xsrc = rs_code;
                        xdst = XD_OPORT;
                    end
                    OP_JMP: begin
                        xsrc = XS_RDR;
                        xdst = XD_PC;
                    end
                    OP_JCC: begin
                        if (cond_true) begin
                            xsrc = XS_RDR;
                            xdst = XD_PC;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Reset forces the idle word straight away. Without this, F0 with run
    // high would show a PC increment while reset is still asserted.
    assign ctrl   = reset_N ? {mmrw, fwr, rwr, xdst, aluop, xsrc} : IDLE_WORD;
    assign halted = (cur_state == ST_HLT);
    assign state  = cur_state;

endmodule

// File: tb/tb_cdec8_ctrl.sv
// tb_cdec8_ctrl
// Testbench for cdec8_ctrl. The bench plays the datapath: it presents each
// instruction byte on I and the flags on SZCy. It then expects the control
// unit to walk a per-instruction sequence of (state, ctrl, halted) values.
// The expected sequence is queued when the instruction is applied and popped
// one entry per clock as the DUT steps through it.

module tb_cdec8_ctrl;

    logic        clock;
    logic        reset_N;
    logic [7:0]  I;
    logic [2:0]  SZCy;
    logic        run;
    logic [16:0] ctrl;
    logic        halted;
    logic [7:0]  state;

    cdec8_ctrl dut (
        .clock   (clock),
        .reset_N (reset_N),
        .I       (I),
        .SZCy    (SZCy),
        .run     (run),
        .ctrl    (ctrl),
        .halted  (halted),
        .state   (state)
    );

    localparam logic [16:0] IDLE_W = 17'h01E0F;
    localparam logic [16:0] FETCH0 = 17'h02810;
    localparam logic [16:0] FETCH1 = 17'h10004;
    localparam logic [16:0] FETCH2 = 17'h00E05;

    typedef struct packed {
        logic [7:0]  st;
        logic [16:0] cw;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [4:0] alu_tab [5] = '{5'h02, 5'h03, 5'h04, 5'h05, 5'h06};

    // Clock generation.
    always #5 clock = ~clock;

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] time limit");
    end

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h required=%0h", tag, observed, expected);
        end
    endtask

    // Builds a control word from its fields.
    function automatic logic [16:0] cw(input logic [1:0] mm, input logic fw, input logic rw,
                                       input logic [3:0] xd, input logic [4:0] al,
                                       input logic [3:0] xs);
        return {mm, fw, rw, xd, al, xs};
    endfunction

    // Register field to bus code: A=1, B=2, C=3.
    function automatic logic [3:0] regCode(input logic [1:0] f);
        case (f)
            2'd0:    return 4'h1;
            2'd1:    return 4'h2;
            2'd2:    return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    task automatic pushExp(input logic [7:0] st, input logic [16:0] w);
        exp_t e;
        e.st = st;
        e.cw = w;
        exp_q.push_back(e);
    endtask

    // Expected per-cycle sequence for one instruction.
    task automatic expectInstr(input logic [7:0] instr, input logic [2:0] flags);
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] rdc;
        logic [3:0] rsc;
        logic       alu_op;
        logic       bad;
        logic       taken;
        op     = instr[7:4];
        rd     = instr[3:2];
        rs     = instr[1:0];
        rdc    = regCode(rd);
        rsc    = regCode(rs);
        alu_op = (op >= 4'h5) && (op <= 4'h9);
        bad    = (op >= 4'hE) ||
                 ((rd == 2'd3) && (op == 4'h1 || op == 4'h3 || op == 4'h4 || alu_op || op == 4'hA)) ||
                 ((rs == 2'd3) && (op == 4'h2 || op == 4'h4 || alu_op || op == 4'hB));
        case (rs)
            2'd0:    taken = flags[1];
            2'd1:    taken = !flags[1];
            2'd2:    taken = flags[0];
            default: taken = flags[2];
        endcase
        pushExp(8'h00, FETCH0);
        pushExp(8'h01, FETCH1);
        pushExp(8'h02, FETCH2);
        pushExp(8'h03, IDLE_W);
        if (bad) begin
            repeat (4) pushExp(8'hFF, IDLE_W);
        end else if (alu_op) begin
            pushExp(8'h0B, cw(2'b00, 1'b0, 1'b0, 4'h6, 5'h00, rsc));
            pushExp(8'h0C, cw(2'b00, 1'b1, 1'b1, 4'hF, alu_tab[int'(op) - 5], rdc));
            pushExp(8'h0D, cw(2'b00, 1'b0, 1'b0, rdc, 5'h00, 4'h4));
        end else begin
            case (op)
                4'h1: begin
                    pushExp(8'h04, FETCH0);
                    pushExp(8'h05, FETCH1);
                    pushExp(8'h07, 17'h00805);
                    pushExp(8'h08, 17'h11E0F);
                    pushExp(8'h06, cw(2'b00, 1'b0, 1'b0, rdc, 5'h00, 4'h5));
                end
                4'h2: begin
                    pushExp(8'h04, FETCH0);
                    pushExp(8'h05, FETCH1);
                    pushExp(8'h07, 17'h00805);
                    pushExp(8'h09, cw(2'b00, 1'b0, 1'b0, 4'h5, 5'h00, rsc));
                    pushExp(8'h0A, 17'h09E0F);
                end
                4'h3: begin
                    pushExp(8'h04, FETCH0);
                    pushExp(8'h05, FETCH1);
                    pushExp(8'h06, cw(2'b00, 1'b0, 1'b0, rdc, 5'h00, 4'h5));
                end
                4'h4: pushExp(8'h06, cw(2'b00, 1'b0, 1'b0, rdc, 5'h00, rsc));
                4'hA: pushExp(8'h06, cw(2'b00, 1'b0, 1'b0, rdc, 5'h00, 4'h8));
                4'hB: pushExp(8'h06, cw(2'b00, 1'b0, 1'b0, 4'h8, 5'h00, rsc));
                4'hC: begin
                    pushExp(8'h04, FETCH0);
                    pushExp(8'h05, FETCH1);
                    pushExp(8'h06, 17'h00005);
                end
                4'hD: begin
                    pushExp(8'h04, FETCH0);
                    pushExp(8'h05, FETCH1);
                    pushExp(8'h06, taken ? 17'h00005 : IDLE_W);
                end
                default: ;
            endcase
        end
    endtask

    // Applies one instruction and follows it cycle by cycle. 'cut' stops
    // early, with the DUT sitting in entry number 'cut'. 'drop_run' lowers
    // run once the fetch has left F0.
    task automatic applyStimulus(input string tag, input logic [7:0] instr,
                                 input logic [2:0] flags, input int cut, input bit drop_run);
        exp_t e;
        int   k;
        I    = instr;
        SZCy = flags;
        run  = 1'b1;
        expectInstr(instr, flags);
        #1;
        k = 0;
        while (exp_q.size() > 0) begin
            if (cut > 0 && k == cut) begin
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            checkOutput($sformatf("%s[%0d].state", tag, k), {24'h0, state}, {24'h0, e.st});
            checkOutput($sformatf("%s[%0d].ctrl", tag, k), {15'h0, ctrl}, {15'h0, e.cw});
            checkOutput($sformatf("%s[%0d].halted", tag, k), {31'h0, halted},
                        {31'h0, (e.st == 8'hFF)});
            if (drop_run && k == 1) run = 1'b0;
            @(posedge clock);
            @(negedge clock);
            k++;
        end
    endtask

    // Asserts reset between clock edges and checks the effect right away.
    task automatic resetPulse(input string tag);
        reset_N = 1'b0;
        #1;
        checkOutput({tag, ".rst_state"}, {24'h0, state}, 32'h00);
        checkOutput({tag, ".rst_ctrl"}, {15'h0, ctrl}, {15'h0, IDLE_W});
        checkOutput({tag, ".rst_halted"}, {31'h0, halted}, 32'h0);
        @(negedge clock);
        reset_N = 1'b1;
    endtask

    // Main stimulus program.
    initial begin
        clock   = 1'b0;
        reset_N = 1'b0;
        run     = 1'b1;
        I       = 8'h00;
        SZCy    = 3'b000;
        #12;
        checkOutput("reset.state", {24'h0, state}, 32'h00);
        checkOutput("reset.ctrl_run_high", {15'h0, ctrl}, {15'h0, IDLE_W});
        checkOutput("reset.halted", {31'h0, halted}, 32'h0);
        run = 1'b0;
        @(negedge clock);
        reset_N = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            @(negedge clock);
            checkOutput($sformatf("idle[%0d].state", c), {24'h0, state}, 32'h00);
            checkOutput($sformatf("idle[%0d].ctrl", c), {15'h0, ctrl}, {15'h0, IDLE_W});
        end

        applyStimulus("nop",      8'h00, 3'b000, 0, 1'b0);
        applyStimulus("nop_junk", 8'h0F, 3'b000, 0, 1'b0);
        applyStimulus("mov_b_a",  8'h44, 3'b000, 0, 1'b0);
        applyStimulus("in_c",     8'hA8, 3'b000, 0, 1'b0);
        applyStimulus("out_b",    8'hB1, 3'b000, 0, 1'b0);
        applyStimulus("ldi_a",    8'h30, 3'b000, 0, 1'b0);
        applyStimulus("ld_b",     8'h14, 3'b000, 0, 1'b0);
        applyStimulus("st_a",     8'h20, 3'b000, 0, 1'b0);
        applyStimulus("st_c",     8'h22, 3'b000, 0, 1'b0);
        applyStimulus("jmp",      8'hC7, 3'b000, 0, 1'b0);
        applyStimulus("jz_take",  8'hD0, 3'b010, 0, 1'b0);
        applyStimulus("jz_skip",  8'hD0, 3'b101, 0, 1'b0);
        applyStimulus("jnz_take", 8'hD1, 3'b000, 0, 1'b0);
        applyStimulus("jnz_skip", 8'hD1, 3'b010, 0, 1'b0);
        applyStimulus("jc_take",  8'hD2, 3'b001, 0, 1'b0);
        applyStimulus("jc_skip",  8'hD2, 3'b110, 0, 1'b0);
        applyStimulus("js_take",  8'hD3, 3'b100, 0, 1'b0);
        applyStimulus("js_skip",  8'hD3, 3'b011, 0, 1'b0);

        for (int k = 0; k < 5; k++) begin
            logic [7:0] alu_instr;
            alu_instr = {4'(k + 5), 2'(k % 3), 2'((k + 1) % 3)};
            applyStimulus($sformatf("alu_%0h", alu_instr), alu_instr, 3'(k), 0, 1'b0);
        end

        applyStimulus("ldi_drop_run", 8'h38, 3'b000, 0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("parked[%0d].state", c), {24'h0, state}, 32'h00);
            checkOutput($sformatf("parked[%0d].ctrl", c), {15'h0, ctrl}, {15'h0, IDLE_W});
            @(posedge clock);
            @(negedge clock);
        end

        applyStimulus("st_cut", 8'h24, 3'b000, 8, 1'b0);
        checkOutput("st_cut.in_sm", {24'h0, state}, 32'h0A);
        checkOutput("st_cut.sm_ctrl", {15'h0, ctrl}, {15'h0, 17'h09E0F});
        resetPulse("st_cut");

        applyStimulus("ill_mov_rd3", 8'h4C, 3'b000, 0, 1'b0);
        run = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("hlt_run_low.state", {24'h0, state}, 32'hFF);
        checkOutput("hlt_run_low.halted", {31'h0, halted}, 32'h1);
        resetPulse("ill_mov_rd3");
        applyStimulus("ill_f0", 8'hF0, 3'b000, 0, 1'b0);
        resetPulse("ill_f0");
        applyStimulus("halt_e0", 8'hE0, 3'b000, 0, 1'b0);
        resetPulse("halt_e0");
        applyStimulus("ill_st_rs3", 8'h23, 3'b000, 0, 1'b0);
        resetPulse("ill_st_rs3");
        applyStimulus("ill_add_rd3", 8'h5C, 3'b000, 0, 1'b0);
        resetPulse("ill_add_rd3");
        applyStimulus("nop_after", 8'h00, 3'b000, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
